// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one debug UART transmitter between four responders
// (0 register-read, 1 memory-read, 2 status, 3 echo). Each responder has a
// one-byte holding slot. The UART is granted round-robin by default.
// Latency: a byte captured at edge k gets tx_en in the cycle after edge k+1
// when the UART is idle and nothing else is pending.
// Backpressure: req_busy[i] stays high while slot i is occupied. A strobe into
// an occupied slot is dropped and sets the sticky req_ovf[i]. No tx_en is
// issued while uart_busy is high.
// Ports: clk/rst_n (async active-low); req_en/req_data per-requester strobe and
// byte; req_busy/req_ovf per-slot status; uart_busy/tx_en/tx_data UART side;
// ack_err sticky flag for a tx_en that uart_busy never acknowledged.
// Build option: define UART_TX_ARB_FIXED_PRIO_EN for fixed priority instead of
// round-robin. Requester 0 has the highest priority in that build.
module uart_tx_arbiter #(
  parameter int DW          = 8,
  parameter int ACK_TIMEOUT = 16,
  parameter int CW          = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req_en,
  input  logic [4*DW-1:0] req_data,
  output logic [3:0]      req_busy,
  output logic [3:0]      req_ovf,
  input  logic            uart_busy,
  output logic            tx_en,
  output logic [DW-1:0]   tx_data,
  output logic            ack_err
);

  typedef enum logic [1:0] {S_Idle, S_Issue, S_Ack, S_Drain} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             last_q, last_d;
  logic [1:0]             gnt_q, gnt_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             hv_q, hv_d;
  logic [3:0][DW-1:0]     hd_q, hd_d;
  logic [3:0]             ovf_q, ovf_d;
  logic                   ack_err_q, ack_err_d;
  logic [DW-1:0]          tx_data_q, tx_data_d;

  logic                   release_en;
  logic [3:0]             rel_vec;
  logic [1:0]             sel;
  logic                   sel_vld;

  // Grant selection. The loop runs from lowest to highest priority, so the
  // last match found is the winner.
`ifdef UART_TX_ARB_FIXED_PRIO_EN
  always_comb begin
    sel     = 2'd0;
    sel_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (hv_q[i]) begin
        sel     = 2'(i);
        sel_vld = 1'b1;
      end
    end
  end
`else
  logic [1:0] rr_idx;
  always_comb begin
    sel     = 2'd0;
    sel_vld = 1'b0;
    rr_idx  = 2'd0;
    // k=4 wraps to last itself (lowest priority); k=1 is last+1 (highest).
    for (int k = 4; k >= 1; k--) begin
      rr_idx = last_q + 2'(k);
      if (hv_q[rr_idx]) begin
        sel     = rr_idx;
        sel_vld = 1'b1;
      end
    end
  end
`endif

  // Grant sequencing FSM
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    ack_err_d  = ack_err_q;
    release_en = 1'b0;
    case (state_q)
      S_Idle: begin
        if (sel_vld && !uart_busy) begin
          gnt_d     = sel;
          tx_data_d = hd_q[sel];
          state_d   = S_Issue;
        end
      end
      S_Issue: begin
        cnt_d   = '0;
        state_d = S_Ack;
      end
      S_Ack: begin
        if (uart_busy) begin
          state_d = S_Drain;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          // The UART never took the byte. Drop it so the other requesters are
          // not blocked.
          ack_err_d  = 1'b1;
          release_en = 1'b1;
          last_d     = gnt_q;
          state_d    = S_Idle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_Drain: begin
        if (!uart_busy) begin
          release_en = 1'b1;
          last_d     = gnt_q;
          state_d    = S_Idle;
        end
      end
      default: state_d = S_Idle;
    endcase
  end

  assign rel_vec = release_en ? (4'b0001 << gnt_q) : 4'b0000;

  // Holding slots. A strobe on the edge that frees the slot is accepted.
  always_comb begin
    hv_d  = hv_q;
    hd_d  = hd_q;
    ovf_d = ovf_q;
    for (int i = 0; i < 4; i++) begin
      if (req_en[i] && (!hv_q[i] || rel_vec[i])) begin
        hv_d[i] = 1'b1;
        hd_d[i] = req_data[i*DW +: DW];
      end else if (rel_vec[i]) begin
        hv_d[i] = 1'b0;
      end else if (req_en[i]) begin
        ovf_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_Idle;
      last_q    <= 2'd3;
      gnt_q     <= 2'd0;
      cnt_q     <= '0;
      hv_q      <= '0;
      hd_q      <= '0;
      ovf_q     <= '0;
      ack_err_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      hv_q      <= hv_d;
      hd_q      <= hd_d;
      ovf_q     <= ovf_d;
      ack_err_q <= ack_err_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_en    = (state_q == S_Issue);
  assign tx_data  = tx_data_q;
  assign req_busy = hv_q;
  assign req_ovf  = ovf_q;
  assign ack_err  = ack_err_q;

endmodule
